idexe_pipe_reg_hz: RTL and testbench
====================================

Name: idexe_pipe_reg_hz

Overview:
Parametrised next-generation ID/EX pipeline register for the 5-stage MIPS core. It carries decode control and datapath fields into EXE, and adds a valid bit, an external stall (hold), a flush (bubble), and built-in load-use hazard detection. That detection drives a stall request back to IF/ID and inserts a bubble into EXE. It also keeps saturating bubble counters for performance visibility.

Parameters:
XLEN, 32, width of qa/qb/imm32/dpc4 datapath fields
REG_AW, 5, register-number width (destReg, rs, rt)
ALUC_W, 4, ALU control width
CNT_W, 16, width of each saturating bubble counter
CLEAR_DATA, 1, 1: bubbles zero the datapath fields; 0: datapath fields hold their previous value on a bubble

Ports:
clk  in  1  pipeline clock, all state on rising edge
clrn  in  1  asynchronous active-low reset
d_valid  in  1  decode slot holds a real instruction
stall_ext  in  1  downstream stall (e.g. memory wait); freeze ID/EX
flush  in  1  squash decode instruction (taken branch/jump)
wreg, m2reg, wmem, aluimm, jal, shift  in  1 each  decode control
aluc  in  ALUC_W  ALU op
destReg, rs, rt  in  REG_AW  dest / source register numbers
use_rs, use_rt  in  1  instruction actually reads rs / rt
qa, qb, imm32, dpc4  in  XLEN  operands, extended immediate, PC+4
ewreg, em2reg, ewmem, ealuimm, ejal, eshift  out  1  registered control
ealuc  out  ALUC_W; edestReg  out  REG_AW
eqa, eqb, eimm32, epc4  out  XLEN  registered datapath
evalid  out  1  EXE slot holds a real instruction
load_use_stall  out  1  combinational: hazard detected, hold PC and IF/ID
stall_up  out  1  combinational: stall_ext | load_use_stall
lu_bubble_cnt, flush_bubble_cnt  out  CNT_W  saturating counters

Behaviour:
- Reset (clrn=0, asynchronous): every registered output and both counters go to 0, so EXE holds a bubble. Release is synchronous to clk.
- hazard = evalid & em2reg & ewreg & (edestReg != 0) & ((use_rs & rs==edestReg) | (use_rt & rt==edestReg)) & d_valid.
- load_use_stall = hazard & ~flush. It is purely combinational and has no registered delay.
- Per rising edge, priority is:
  1. stall_ext=1: all E registers and counters hold.
  2. flush=1: insert bubble; flush_bubble_cnt += 1 (saturating).
  3. load_use_stall=1: insert bubble; lu_bubble_cnt += 1 (saturating).
  4. Otherwise capture: evalid<=d_valid. When d_valid=1, all fields load from inputs. When d_valid=0, the slot is treated as a bubble, without counting.
- Bubble: evalid, ewreg, em2reg, ewmem, ejal, eshift all go to 0. ealuc, ealuimm and edestReg go to 0. Datapath fields go to 0 if CLEAR_DATA=1, else they hold.
- Latency: 1 cycle from input to E output on capture.
- Load-use sequence:
  - Cycle N: load in E, dependent instruction in D, stall asserted.
  - Edge N+1: bubble enters E; the upstream holds the dependent instruction in D.
  - Cycle N+1: hazard is 0 because evalid=0.
  - Edge N+2: the dependent instruction is captured.
  - Result: exactly one bubble per load-use.
- Load writing $0 (edestReg=0) never stalls.
- flush and hazard in the same cycle: flush wins and is counted once. lu_bubble_cnt does not change.
- stall_ext with hazard: load_use_stall still reflects the hazard, but nothing is captured or counted until stall_ext drops.
- Counters stop at all-ones and never wrap.
- All inputs are registered with nonblocking assignments only. eqa/eqb update on the same edge as the control fields.

Decomposition:
- Shared package mips_pkg: XLEN, REG_AW and ALUC_W defaults; ALUC opcode constants; a packed struct for the ID/EX control bundle {wreg, m2reg, wmem, aluc, aluimm, jal, shift}; a BUBBLE constant of that struct, all zeros.
- One natural sub-module, sat_counter (CNT_W, inc, async clrn), instantiated twice.
- Hazard compare stays inline.

Test Plan:
1. Reset: drive all inputs to 1s, clrn=0 mid-cycle → all outputs 0 immediately (before the next edge); release clrn, then d_valid=1, qa=0x12345678 → eqa=0x12345678 and evalid=1 one edge later.
2. Load-use: E holds lw with em2reg=1, ewreg=1, edestReg=8; D holds rs=8, use_rs=1 → load_use_stall=1 and stall_up=1 that cycle; next edge evalid=0 and lu_bubble_cnt=1; following edge the dependent instruction is captured.
3. No false stall: edestReg=0 load, or rt=8 with use_rt=0 → load_use_stall=0 and normal capture.
4. flush + hazard in the same cycle → bubble; flush_bubble_cnt=1, lu_bubble_cnt=0, load_use_stall=0.
5. stall_ext=1 for 3 cycles while inputs change → all E outputs and counters unchanged; capture resumes one edge after stall_ext falls.
6. Saturation: CNT_W=2, force 5 consecutive load-use bubbles → lu_bubble_cnt stops at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core.
// Holds the default field widths, the ALU opcodes and the ID/EX control bundle.
package mips_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;
    localparam int ALUC_W_DEF = 4;

    // ALU control encoding used by the decoder (x000 add, x100 sub, ...).
    localparam logic [ALUC_W_DEF-1:0] ALUC_ADD = 4'b0000;
    localparam logic [ALUC_W_DEF-1:0] ALUC_SUB = 4'b0100;
    localparam logic [ALUC_W_DEF-1:0] ALUC_AND = 4'b0001;
    localparam logic [ALUC_W_DEF-1:0] ALUC_OR  = 4'b0101;
    localparam logic [ALUC_W_DEF-1:0] ALUC_XOR = 4'b0010;
    localparam logic [ALUC_W_DEF-1:0] ALUC_LUI = 4'b0110;
    localparam logic [ALUC_W_DEF-1:0] ALUC_SLL = 4'b0011;
    localparam logic [ALUC_W_DEF-1:0] ALUC_SRL = 4'b0111;
    localparam logic [ALUC_W_DEF-1:0] ALUC_SRA = 4'b1111;

    typedef struct packed {
        logic                  wreg;
        logic                  m2reg;
        logic                  wmem;
        logic [ALUC_W_DEF-1:0] aluc;
        logic                  aluimm;
        logic                  jal;
        logic                  shift;
    } idex_ctrl_t;

    localparam idex_ctrl_t BUBBLE = '0;

    // A load is the only producer whose result is not ready at the end of EXE.
    function automatic logic is_load(input idex_ctrl_t ctrl);
        return ctrl.m2reg & ctrl.wreg;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc and sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/idexe_pipe_reg_hz.sv
// ID/EX pipeline register with valid bit, external hold, flush and
// load-use hazard detection that bubbles EXE and stalls IF/ID.
module idexe_pipe_reg_hz
    import mips_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int ALUC_W     = ALUC_W_DEF,
    parameter int CNT_W      = 16,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              d_valid,
    input  logic              stall_ext,
    input  logic              flush,
    input  logic              wreg,
    input  logic              m2reg,
    input  logic              wmem,
    input  logic              aluimm,
    input  logic              jal,
    input  logic              shift,
    input  logic [ALUC_W-1:0] aluc,
    input  logic [REG_AW-1:0] destReg,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              use_rs,
    input  logic              use_rt,
    input  logic [XLEN-1:0]   qa,
    input  logic [XLEN-1:0]   qb,
    input  logic [XLEN-1:0]   imm32,
    input  logic [XLEN-1:0]   dpc4,
    output logic              ewreg,
    output logic              em2reg,
    output logic              ewmem,
    output logic              ealuimm,
    output logic              ejal,
    output logic              eshift,
    output logic [ALUC_W-1:0] ealuc,
    output logic [REG_AW-1:0] edestReg,
    output logic [XLEN-1:0]   eqa,
    output logic [XLEN-1:0]   eqb,
    output logic [XLEN-1:0]   eimm32,
    output logic [XLEN-1:0]   epc4,
    output logic              evalid,
    output logic              load_use_stall,
    output logic              stall_up,
    output logic [CNT_W-1:0]  lu_bubble_cnt,
    output logic [CNT_W-1:0]  flush_bubble_cnt
);

    idex_ctrl_t d_ctrl;
    idex_ctrl_t e_ctrl;

    logic rs_hit;
    logic rt_hit;
    logic hazard;
    logic capture;
    logic lu_inc;
    logic flush_inc;

    // The control bundle is sized by the package; ALUC_W is expected to match it.
    assign d_ctrl = '{
        wreg:   wreg,
        m2reg:  m2reg,
        wmem:   wmem,
        aluc:   ALUC_W_DEF'(aluc),
        aluimm: aluimm,
        jal:    jal,
        shift:  shift
    };

    assign ewreg   = e_ctrl.wreg;
    assign em2reg  = e_ctrl.m2reg;
    assign ewmem   = e_ctrl.wmem;
    assign ealuc   = ALUC_W'(e_ctrl.aluc);
    assign ealuimm = e_ctrl.aluimm;
    assign ejal    = e_ctrl.jal;
    assign eshift  = e_ctrl.shift;

    assign rs_hit = use_rs && (rs == edestReg);
    assign rt_hit = use_rt && (rt == edestReg);

    // $0 is never really written, so a load targeting it cannot create a hazard.
    assign hazard = evalid && is_load(e_ctrl) && (edestReg != '0)
                    && (rs_hit || rt_hit) && d_valid;

    assign load_use_stall = hazard && !flush;
    assign stall_up       = stall_ext || load_use_stall;

    assign capture   = !stall_ext && !flush && !load_use_stall && d_valid;
    assign flush_inc = !stall_ext && flush;
    assign lu_inc    = !stall_ext && load_use_stall;

    // NOTE: every pipeline register is assigned with <= so all E fields update
    // together from the values present before the edge.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            evalid   <= 1'b0;
            e_ctrl   <= BUBBLE;
            edestReg <= '0;
            eqa      <= '0;
            eqb      <= '0;
            eimm32   <= '0;
            epc4     <= '0;
        end else if (!stall_ext) begin
            if (capture) begin
                evalid   <= 1'b1;
                e_ctrl   <= d_ctrl;
                edestReg <= destReg;
                eqa      <= qa;
                eqb      <= qb;
                eimm32   <= imm32;
                epc4     <= dpc4;
            end else begin
                evalid   <= 1'b0;
                e_ctrl   <= BUBBLE;
                edestReg <= '0;
                if (CLEAR_DATA) begin
                    eqa    <= '0;
                    eqb    <= '0;
                    eimm32 <= '0;
                    epc4   <= '0;
                end
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (lu_inc),
        .cnt  (lu_bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk  (clk),
        .clrn (clrn),
        .inc  (flush_inc),
        .cnt  (flush_bubble_cnt)
    );

endmodule

// File: tb/tb_idexe_pipe_reg_hz.sv
// Directed bench for idexe_pipe_reg_hz: reset, capture, load-use, flush,
// external stall and counter saturation (counters built 2 bits wide).
module tb_idexe_pipe_reg_hz;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int ALUC_W = 4;
    localparam int CNT_W  = 2;

    logic              clk;
    logic              clrn;
    logic              d_valid, stall_ext, flush;
    logic              wreg, m2reg, wmem, aluimm, jal, shift;
    logic [ALUC_W-1:0] aluc;
    logic [REG_AW-1:0] destReg, rs, rt;
    logic              use_rs, use_rt;
    logic [XLEN-1:0]   qa, qb, imm32, dpc4;
    logic              ewreg, em2reg, ewmem, ealuimm, ejal, eshift;
    logic [ALUC_W-1:0] ealuc;
    logic [REG_AW-1:0] edestReg;
    logic [XLEN-1:0]   eqa, eqb, eimm32, epc4;
    logic              evalid, load_use_stall, stall_up;
    logic [CNT_W-1:0]  lu_bubble_cnt, flush_bubble_cnt;

    int n_cmp;
    int n_err;

    idexe_pipe_reg_hz #(
        .XLEN(XLEN), .REG_AW(REG_AW), .ALUC_W(ALUC_W), .CNT_W(CNT_W), .CLEAR_DATA(1'b1)
    ) dut (
        .clk(clk), .clrn(clrn), .d_valid(d_valid), .stall_ext(stall_ext), .flush(flush),
        .wreg(wreg), .m2reg(m2reg), .wmem(wmem), .aluimm(aluimm), .jal(jal), .shift(shift),
        .aluc(aluc), .destReg(destReg), .rs(rs), .rt(rt), .use_rs(use_rs), .use_rt(use_rt),
        .qa(qa), .qb(qb), .imm32(imm32), .dpc4(dpc4),
        .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem), .ealuimm(ealuimm), .ejal(ejal),
        .eshift(eshift), .ealuc(ealuc), .edestReg(edestReg),
        .eqa(eqa), .eqb(eqb), .eimm32(eimm32), .epc4(epc4), .evalid(evalid),
        .load_use_stall(load_use_stall), .stall_up(stall_up),
        .lu_bubble_cnt(lu_bubble_cnt), .flush_bubble_cnt(flush_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one decode-slot instruction; qb/imm32/dpc4 are derived from qa.
    task automatic drive(input logic v, input logic w, input logic m,
                         input logic [REG_AW-1:0] dst,
                         input logic [REG_AW-1:0] rs_n, input logic urs,
                         input logic [REG_AW-1:0] rt_n, input logic urt,
                         input logic [XLEN-1:0] a);
        d_valid = v;
        wreg    = w;
        m2reg   = m;
        wmem    = 1'b0;
        aluimm  = m;
        jal     = 1'b0;
        shift   = 1'b0;
        aluc    = 4'b0101;
        destReg = dst;
        rs      = rs_n;
        use_rs  = urs;
        rt      = rt_n;
        use_rt  = urt;
        qa      = a;
        qb      = a ^ 32'h0000_FFFF;
        imm32   = 32'h0000_0010;
        dpc4    = 32'h0040_0004;
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        #3;
        tick();
        clrn = 1'b1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        clrn      = 1'b0;
        stall_ext = 1'b0;
        flush     = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        tick();
        clrn = 1'b1;

        // Plain capture: one-edge latency, all fields loaded.
        drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd1, 1'b1, 5'd2, 1'b1, 32'hAAAA_5555);
        tick();
        check("cap_evalid", 64'(evalid), 64'd1);
        check("cap_eqa", 64'(eqa), 64'hAAAA_5555);
        check("cap_eqb", 64'(eqb), 64'hAAAA_AAAA);
        check("cap_edest", 64'(edestReg), 64'd3);
        check("cap_ewreg", 64'(ewreg), 64'd1);
        check("cap_ealuc", 64'(ealuc), 64'h5);

        // Plain flush bubble.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_evalid", 64'(evalid), 64'd0);
        check("flush_eqa_cleared", 64'(eqa), 64'd0);
        check("flush_cnt_1", 64'(flush_bubble_cnt), 64'd1);

        // Asynchronous reset mid-cycle with every input at 1.
        tick();
        check("pre_rst_evalid", 64'(evalid), 64'd1);
        d_valid = 1'b1; stall_ext = 1'b1; flush = 1'b1;
        wreg = 1'b1; m2reg = 1'b1; wmem = 1'b1; aluimm = 1'b1; jal = 1'b1; shift = 1'b1;
        aluc = '1; destReg = '1; rs = '1; rt = '1; use_rs = 1'b1; use_rt = 1'b1;
        qa = '1; qb = '1; imm32 = '1; dpc4 = '1;
        #2;
        clrn = 1'b0;
        #1;
        check("rst_evalid", 64'(evalid), 64'd0);
        check("rst_eqa", 64'(eqa), 64'd0);
        check("rst_epc4", 64'(epc4), 64'd0);
        check("rst_ctrl", 64'({ewreg, em2reg, ewmem, ealuimm, ejal, eshift, ealuc}), 64'd0);
        check("rst_edest", 64'(edestReg), 64'd0);
        check("rst_flush_cnt", 64'(flush_bubble_cnt), 64'd0);
        tick();
        clrn = 1'b1;
        stall_ext = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h1234_5678);
        tick();
        check("post_rst_eqa", 64'(eqa), 64'h1234_5678);
        check("post_rst_evalid", 64'(evalid), 64'd1);

        // Load-use: lw $8 in E, dependent reads rs=$8.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0000_1111);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 1'b1, 5'd0, 1'b0, 32'h0000_2222);
        #1;
        check("lu_stall", 64'(load_use_stall), 64'd1);
        check("lu_stall_up", 64'(stall_up), 64'd1);
        tick();
        check("lu_bubble_evalid", 64'(evalid), 64'd0);
        check("lu_cnt_1", 64'(lu_bubble_cnt), 64'd1);
        check("lu_stall_cleared", 64'(load_use_stall), 64'd0);
        tick();
        check("lu_dep_evalid", 64'(evalid), 64'd1);
        check("lu_dep_eqa", 64'(eqa), 64'h0000_2222);
        check("lu_dep_edest", 64'(edestReg), 64'd9);

        // No false stall: load into $0.
        drive(1'b1, 1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0000_0A0A);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 1'b1, 5'd0, 1'b1, 32'h0000_3333);
        #1;
        check("r0_no_stall", 64'(load_use_stall), 64'd0);
        tick();
        check("r0_capture_eqa", 64'(eqa), 64'h0000_3333);

        // No false stall: rt matches but is not read.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0000_0B0B);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd1, 1'b1, 5'd8, 1'b0, 32'h0000_4444);
        #1;
        check("rt_unused_no_stall", 64'(load_use_stall), 64'd0);
        tick();
        check("rt_unused_eqa", 64'(eqa), 64'h0000_4444);
        check("rt_unused_lu_cnt", 64'(lu_bubble_cnt), 64'd1);

        // Flush and hazard together: flush wins, counted once.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0000_0C0C);
        tick();
        drive(1'b1, 1'b1, 1'b0, 5'd7, 5'd8, 1'b1, 5'd0, 1'b0, 32'h0000_5555);
        flush = 1'b1;
        #1;
        check("fh_no_lu_stall", 64'(load_use_stall), 64'd0);
        tick();
        flush = 1'b0;
        check("fh_evalid", 64'(evalid), 64'd0);
        check("fh_flush_cnt", 64'(flush_bubble_cnt), 64'd1);
        check("fh_lu_cnt_same", 64'(lu_bubble_cnt), 64'd1);

        // External stall: lw $8 in E, D changes for 3 edges, nothing moves.
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0000_6666);
        tick();
        stall_ext = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd8, 1'b1, 5'd0, 1'b0, 32'h0000_7001);
        #1;
        check("se_lu_stall_seen", 64'(load_use_stall), 64'd1);
        check("se_stall_up", 64'(stall_up), 64'd1);
        tick();
        check("se1_eqa", 64'(eqa), 64'h0000_6666);
        check("se1_lu_cnt", 64'(lu_bubble_cnt), 64'd1);
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd2, 1'b1, 5'd0, 1'b0, 32'h0000_7002);
        tick();
        check("se2_eqa", 64'(eqa), 64'h0000_6666);
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd2, 1'b1, 5'd0, 1'b0, 32'h0000_7003);
        tick();
        check("se3_eqa", 64'(eqa), 64'h0000_6666);
        check("se3_edest", 64'(edestReg), 64'd8);
        check("se3_evalid", 64'(evalid), 64'd1);
        check("se3_flush_cnt", 64'(flush_bubble_cnt), 64'd1);
        stall_ext = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd2, 1'b1, 5'd0, 1'b0, 32'h0000_7004);
        tick();
        check("se_resume_eqa", 64'(eqa), 64'h0000_7004);
        check("se_resume_edest", 64'(edestReg), 64'd4);

        // Saturation: chained dependent loads alternate capture / bubble.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 5'd8, 5'd8, 1'b1, 5'd0, 1'b0, 32'h0000_8888);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 2)  check("sat_cnt_after_1", 64'(lu_bubble_cnt), 64'd1);
            if (i == 6)  check("sat_cnt_after_3", 64'(lu_bubble_cnt), 64'd3);
            if (i == 9)  check("sat_capture_evalid", 64'(evalid), 64'd1);
            if (i == 10) check("sat_cnt_after_5", 64'(lu_bubble_cnt), 64'd3);
        end
        check("sat_flush_cnt", 64'(flush_bubble_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
